// File: rtl/ioctl_sdram_loader.sv
// Purpose : relocates HPS ioctl download bytes into SDRAM regions and arbitrates the SDRAM port with the core.
// Latency : ioctl_wr to sdram_req is 2 cycles when idle (push, pop in IDLE, then WREQ).
// Backpres: no stall toward ioctl; bytes arriving to a full FIFO are dropped and flagged in overrun.
//
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   ioctl_*             - HPS download port (download, index, wr strobe, addr, data)
//   core_*              - core SDRAM request port, passed through when the loader is idle
//   sdram_*             - SDRAM controller req/ready port
//   hold_reset          - holds the core in reset while a load is in progress or draining
//   load_done           - one-cycle pulse once every byte of a non-empty load has landed
//   overrun, range_err  - sticky drop flags, cleared at the start of each download
//   byte_count          - bytes written to SDRAM in the current load
module ioctl_sdram_loader #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [24:0] ROM_BASE   = 25'h000000,
    parameter logic [24:0] CART_BASE  = 25'h010000,
    parameter logic [24:0] ROM_MAX    = 25'h010000,
    parameter logic [24:0] CART_MAX   = 25'h010000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic [24:0] core_addr,
    input  logic [7:0]  core_din,
    input  logic        core_req,
    input  logic        core_rnw,
    output logic        core_ready,
    output logic [24:0] sdram_addr,
    output logic [7:0]  sdram_din,
    output logic        sdram_req,
    output logic        sdram_rnw,
    input  logic        sdram_ready,
    output logic        hold_reset,
    output logic        load_done,
    output logic        overrun,
    output logic        range_err,
    output logic [24:0] byte_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WREQ, GAP, PASS} state_t;

    state_t      state;
    entry_t      fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    entry_t      fifo_head;

    entry_t      in_entry;
    logic        in_vld;
    logic        in_bad;
    logic        pop;
    logic        push;
    logic        drop_full;

    logic        dl_q;
    logic        dl_rise;
    logic        pushed;
    logic        done_now;
    logic [24:0] ld_addr;
    logic [7:0]  ld_din;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

    assign dl_rise = ioctl_download & ~dl_q;

    // Relocation and range check of the incoming byte.
    always_comb begin
        in_vld   = 1'b0;
        in_bad   = 1'b0;
        in_entry = '{addr: 25'd0, data: ioctl_data};
        if (ioctl_wr && ioctl_download) begin
            if (ioctl_index == 8'd0) begin
                if (ioctl_addr < ROM_MAX) begin
                    in_vld        = 1'b1;
                    in_entry.addr = ROM_BASE + ioctl_addr;
                end else begin
                    in_bad = 1'b1;
                end
            end else if (ioctl_index == 8'd1) begin
                if (ioctl_addr < CART_MAX) begin
                    in_vld        = 1'b1;
                    in_entry.addr = CART_BASE + ioctl_addr;
                end else begin
                    in_bad = 1'b1;
                end
            end
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign pop       = (state == IDLE) && !fifo_empty;
    assign push      = in_vld && (!fifo_full || pop);
    assign drop_full = in_vld && fifo_full && !pop;

    // Completion of a load: nothing left to download, queue or write. Also
    // covers a download that ends after its last byte already drained.
    assign done_now = pushed && !ioctl_download && fifo_empty &&
                      ((state == GAP) || (state == IDLE));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= in_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ld_addr    <= '0;
            ld_din     <= '0;
            dl_q       <= 1'b0;
            pushed     <= 1'b0;
            byte_count <= '0;
            overrun    <= 1'b0;
            range_err  <= 1'b0;
            load_done  <= 1'b0;
            hold_reset <= 1'b0;
        end else begin
            dl_q       <= ioctl_download;
            load_done  <= done_now;
            hold_reset <= ioctl_download || !fifo_empty || (state != IDLE);

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // New download clears the per-load flags; a drop in that same
            // cycle still registers.
            if (dl_rise) begin
                overrun   <= drop_full;
                range_err <= in_bad;
                pushed    <= push;
            end else begin
                overrun   <= overrun | drop_full;
                range_err <= range_err | in_bad;
                if (done_now) begin
                    pushed <= 1'b0;
                end else if (push) begin
                    pushed <= 1'b1;
                end
            end

            if (dl_rise) begin
                byte_count <= '0;
            end else if ((state == WREQ) && sdram_ready) begin
                byte_count <= byte_count + 25'd1;
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        ld_addr <= fifo_head.addr;
                        ld_din  <= fifo_head.data;
                        state   <= WREQ;
                    end else if (core_req) begin
                        state <= PASS;
                    end
                end
                WREQ: begin
                    if (sdram_ready) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                PASS: begin
                    if (sdram_ready || !core_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The core owns the controller port only in PASS; otherwise the loader
    // registers drive it and req is high only while a write is outstanding.
    always_comb begin
        if (state == PASS) begin
            sdram_addr = core_addr;
            sdram_din  = core_din;
            sdram_req  = core_req;
            sdram_rnw  = core_rnw;
            core_ready = sdram_ready;
        end else begin
            sdram_addr = ld_addr;
            sdram_din  = ld_din;
            sdram_req  = (state == WREQ);
            sdram_rnw  = 1'b0;
            core_ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
`timescale 1ns/1ps
module tb_ioctl_sdram_loader;

    localparam int unsigned DEPTH     = 8;
    localparam logic [24:0] ROM_BASE  = 25'h000000;
    localparam logic [24:0] CART_BASE = 25'h010000;
    localparam logic [24:0] ROM_MAX   = 25'h010000;
    localparam logic [24:0] CART_MAX  = 25'h010000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_data = 8'd0;
    logic [24:0] core_addr = 25'd0;
    logic [7:0]  core_din = 8'd0;
    logic        core_req = 1'b0;
    logic        core_rnw = 1'b1;
    logic        core_ready;
    logic [24:0] sdram_addr;
    logic [7:0]  sdram_din;
    logic        sdram_req;
    logic        sdram_rnw;
    logic        sdram_ready = 1'b0;
    logic        hold_reset;
    logic        load_done;
    logic        overrun;
    logic        range_err;
    logic [24:0] byte_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ioctl_sdram_loader #(
        .FIFO_DEPTH(DEPTH), .ROM_BASE(ROM_BASE), .CART_BASE(CART_BASE),
        .ROM_MAX(ROM_MAX), .CART_MAX(CART_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .core_addr(core_addr), .core_din(core_din), .core_req(core_req), .core_rnw(core_rnw),
        .core_ready(core_ready),
        .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_req(sdram_req), .sdram_rnw(sdram_rnw),
        .sdram_ready(sdram_ready),
        .hold_reset(hold_reset), .load_done(load_done), .overrun(overrun), .range_err(range_err),
        .byte_count(byte_count)
    );

    // SDRAM controller model: pulses ready lat cycles after req is seen, unless
    // stalled. Every completed transaction is logged; core traffic is reads.
    int          lat = 3;
    bit          stall = 1'b0;
    int          cnt = 0;
    int          done_cnt = 0;
    logic [32:0] wr_q [$];
    logic [24:0] rd_addr_q [$];
    int          rd_seen_q [$];

    always @(negedge clk) begin
        if (load_done) done_cnt++;
        if (reset) begin
            sdram_ready = 1'b0;
            cnt = 0;
        end else if (sdram_ready) begin
            sdram_ready = 1'b0;
            cnt = 0;
        end else if (sdram_req && !stall) begin
            if (cnt >= lat - 1) begin
                sdram_ready = 1'b1;
                cnt = 0;
                if (sdram_rnw) begin
                    rd_addr_q.push_back(sdram_addr);
                    rd_seen_q.push_back(wr_q.size());
                end else begin
                    wr_q.push_back({sdram_addr, sdram_din});
                end
            end else begin
                cnt++;
            end
        end else if (!sdram_req) begin
            cnt = 0;
        end
    end

    // Reference model of the per-load expectation.
    logic [32:0] exp_q [$];
    bit          exp_range;
    int          wr_base;
    int          done_base;

    function automatic void relocate(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                                     output bit keep, output bit bad, output logic [32:0] ent);
        logic [24:0] t;
        keep = 1'b0; bad = 1'b0; ent = '0; t = '0;
        if (idx == 8'd0) begin
            if (a < ROM_MAX) begin keep = 1'b1; t = ROM_BASE + a; end else bad = 1'b1;
        end else if (idx == 8'd1) begin
            if (a < CART_MAX) begin keep = 1'b1; t = CART_BASE + a; end else bad = 1'b1;
        end
        ent = {t, d};
    endfunction

    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d, input bit record);
        bit keep, bad;
        logic [32:0] ent;
        ioctl_index = idx; ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
        if (record) begin
            relocate(idx, a, d, keep, bad, ent);
            if (keep) exp_q.push_back(ent);
            if (bad) exp_range = 1'b1;
        end
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic begin_load();
        exp_q.delete();
        exp_range = 1'b0;
        wr_base = wr_q.size();
        done_base = done_cnt;
        ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_load();
        ioctl_download = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!hold_reset) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_core(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (rd_addr_q.size() > base) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        core_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({sdram_req, sdram_rnw, core_ready, hold_reset, load_done, overrun, range_err} !== 7'd0)
            begin errors++; $display("FAIL reset_flags: got %b required 0000000", {sdram_req, sdram_rnw, core_ready, hold_reset, load_done, overrun, range_err}); end
        checks++; if (byte_count !== 25'd0) begin errors++; $display("FAIL reset_count: got %h required 0", byte_count); end
        checks++; if ({sdram_addr, sdram_din} !== 33'd0) begin errors++; $display("FAIL reset_bus: got %h required 0", {sdram_addr, sdram_din}); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rom_load();
        logic [7:0] dat [4];
        bit ok;
        dat[0] = 8'hAA; dat[1] = 8'hBB; dat[2] = 8'hCC; dat[3] = 8'hDD;
        lat = 3;
        begin_load();
        for (int i = 0; i < 4; i++) begin
            wr_byte(8'd0, 25'(i), dat[i], 1'b1);
            if (i == 0) begin
                checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL lat_early: sdram_req got %b required 0", sdram_req); end
                @(negedge clk);
                checks++; if (sdram_req !== 1'b1 || sdram_addr !== ROM_BASE || sdram_din !== 8'hAA)
                    begin errors++; $display("FAIL lat_2cyc: req/addr/din got %b/%h/%h required 1/%h/aa", sdram_req, sdram_addr, sdram_din, ROM_BASE); end
                checks++; if (hold_reset !== 1'b1) begin errors++; $display("FAIL hold_during: got %b required 1", hold_reset); end
                repeat (8) @(negedge clk);
            end else if (i < 3) begin
                repeat (9) @(negedge clk);
            end
        end
        end_load();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rom_drain: hold_reset still 1 required 0"); end
        checks++; if (wr_q.size() - wr_base !== 4) begin errors++; $display("FAIL rom_nwr: got %0d required 4", wr_q.size() - wr_base); end
        for (int i = 0; i < 4 && wr_base + i < wr_q.size(); i++) begin
            checks++; if (wr_q[wr_base + i] !== exp_q[i]) begin errors++; $display("FAIL rom_wr%0d: got %h required %h", i, wr_q[wr_base + i], exp_q[i]); end
        end
        checks++; if (byte_count !== 25'd4) begin errors++; $display("FAIL rom_count: got %0d required 4", byte_count); end
        checks++; if (done_cnt - done_base !== 1) begin errors++; $display("FAIL rom_done: pulses got %0d required 1", done_cnt - done_base); end
        checks++; if (hold_reset !== 1'b0) begin errors++; $display("FAIL rom_hold: got %b required 0", hold_reset); end
    endtask

    task automatic test_cart();
        bit ok;
        begin_load();
        checks++; if (byte_count !== 25'd0) begin errors++; $display("FAIL start_clear: byte_count got %0d required 0", byte_count); end
        wr_byte(8'd1, 25'h0005, 8'h5A, 1'b1);
        end_load();
        wait_idle(ok);
        checks++; if (!ok || wr_q.size() - wr_base !== 1) begin errors++; $display("FAIL cart_nwr: got %0d required 1", wr_q.size() - wr_base); end
        else begin
            checks++; if (wr_q[wr_base] !== {25'h010005, 8'h5A}) begin errors++; $display("FAIL cart_wr: got %h required %h", wr_q[wr_base], {25'h010005, 8'h5A}); end
        end
        checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL cart_range: got %b required 0", range_err); end
    endtask

    task automatic test_range();
        begin_load();
        wr_byte(8'd0, 25'h010000, 8'h77, 1'b1);
        end_load();
        repeat (20) @(negedge clk);
        checks++; if (wr_q.size() - wr_base !== 0) begin errors++; $display("FAIL range_nwr: got %0d required 0", wr_q.size() - wr_base); end
        checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_flag: got %b required 1", range_err); end
        checks++; if (done_cnt - done_base !== 0) begin errors++; $display("FAIL range_done: got %0d required 0", done_cnt - done_base); end
        begin_load();
        wr_byte(8'd2, 25'h000000, 8'h11, 1'b1);
        wr_byte(8'd2, 25'h000003, 8'h22, 1'b1);
        end_load();
        repeat (20) @(negedge clk);
        checks++; if (wr_q.size() - wr_base !== 0) begin errors++; $display("FAIL idx2_nwr: got %0d required 0", wr_q.size() - wr_base); end
        checks++; if ({range_err, overrun} !== 2'b00) begin errors++; $display("FAIL idx2_flags: got %b required 00", {range_err, overrun}); end
    endtask

    task automatic test_random();
        bit ok;
        for (int ld = 0; ld < 4; ld++) begin
            int n;
            n = $urandom_range(15, 5);
            lat = $urandom_range(3, 1);
            begin_load();
            for (int i = 0; i < n; i++) begin
                logic [7:0]  idx;
                logic [24:0] a;
                int r, r2;
                r = $urandom_range(9, 0);
                idx = (r < 4) ? 8'd0 : (r < 8) ? 8'd1 : (r == 8) ? 8'd2 : 8'($urandom_range(255, 3));
                r2 = $urandom_range(3, 0);
                if (r2 == 0)      a = ROM_MAX - 25'd2 + 25'($urandom_range(3, 0));
                else if (r2 == 1) a = 25'($urandom);
                else              a = 25'($urandom_range(32'h0FFFF, 0));
                wr_byte(idx, a, 8'($urandom), 1'b1);
                repeat ($urandom_range(9, 5)) @(negedge clk);
            end
            end_load();
            wait_idle(ok);
            checks++; if (!ok || wr_q.size() - wr_base !== exp_q.size())
                begin errors++; $display("FAIL rnd%0d_nwr: got %0d required %0d", ld, wr_q.size() - wr_base, exp_q.size()); end
            else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++; if (wr_q[wr_base + i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_wr%0d: got %h required %h", ld, i, wr_q[wr_base + i], exp_q[i]); end
                end
            end
            checks++; if (byte_count !== 25'(exp_q.size())) begin errors++; $display("FAIL rnd%0d_count: got %0d required %0d", ld, byte_count, exp_q.size()); end
            checks++; if (range_err !== exp_range || overrun !== 1'b0) begin errors++; $display("FAIL rnd%0d_flags: range/over got %b/%b required %b/0", ld, range_err, overrun, exp_range); end
            checks++; if (done_cnt - done_base !== ((exp_q.size() > 0) ? 1 : 0))
                begin errors++; $display("FAIL rnd%0d_done: got %0d required %0d", ld, done_cnt - done_base, (exp_q.size() > 0) ? 1 : 0); end
        end
    endtask

    // The core sits in PASS with ready held off, so no pop can free a slot:
    // only the first DEPTH bytes of a 12-byte burst fit.
    task automatic test_overrun();
        bit ok, okc;
        int rd_base;
        logic [32:0] ent;
        bit keep, bad;
        lat = 2;
        begin_load();
        rd_base = rd_addr_q.size();
        stall = 1'b1;
        core_addr = 25'h1ABCDE; core_rnw = 1'b1; core_req = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            relocate(8'd0, 25'h100 + 25'(i), d, keep, bad, ent);
            if (i < DEPTH) exp_q.push_back(ent);
            wr_byte(8'd0, 25'h100 + 25'(i), d, 1'b0);
        end
        end_load();
        repeat (86) @(negedge clk);
        stall = 1'b0;
        wait_core(rd_base, okc);
        wait_idle(ok);
        checks++; if (!okc || rd_addr_q[rd_base] !== 25'h1ABCDE) begin errors++; $display("FAIL ovr_core: completed %b required 1", okc); end
        else begin
            checks++; if (rd_seen_q[rd_base] !== wr_base) begin errors++; $display("FAIL ovr_preempt: loader writes before core got %0d required 0", rd_seen_q[rd_base] - wr_base); end
        end
        checks++; if (!ok || wr_q.size() - wr_base !== DEPTH) begin errors++; $display("FAIL ovr_nwr: got %0d required %0d", wr_q.size() - wr_base, DEPTH); end
        else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++; if (wr_q[wr_base + i] !== exp_q[i]) begin errors++; $display("FAIL ovr_wr%0d: got %h required %h", i, wr_q[wr_base + i], exp_q[i]); end
            end
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b required 1", overrun); end
        checks++; if (byte_count !== 25'(DEPTH)) begin errors++; $display("FAIL ovr_count: got %0d required %0d", byte_count, DEPTH); end
    endtask

    task automatic test_core_arb();
        bit ok, okc;
        int rd_base, viol;
        // Core request arriving while the FIFO holds bytes waits for the drain.
        lat = 2;
        viol = 0;
        begin_load();
        rd_base = rd_addr_q.size();
        for (int i = 0; i < 3; i++) wr_byte(8'd1, 25'h40 + 25'(i), 8'($urandom), 1'b1);
        core_addr = 25'h0ABCDE; core_rnw = 1'b1; core_req = 1'b1;
        okc = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #2;
            if (core_ready && !sdram_rnw) viol++;
            if (rd_addr_q.size() > rd_base) begin okc = 1'b1; break; end
        end
        @(negedge clk);
        core_req = 1'b0;
        end_load();
        wait_idle(ok);
        checks++; if (viol !== 0) begin errors++; $display("FAIL arb_ready: core_ready high during loader got %0d required 0", viol); end
        checks++; if (!okc) begin errors++; $display("FAIL arb_core: completed %b required 1", okc); end
        else begin
            checks++; if (rd_seen_q[rd_base] - wr_base !== 3) begin errors++; $display("FAIL arb_order: loader writes before core got %0d required 3", rd_seen_q[rd_base] - wr_base); end
            checks++; if (rd_addr_q[rd_base] !== 25'h0ABCDE) begin errors++; $display("FAIL arb_addr: got %h required 0abcde", rd_addr_q[rd_base]); end
        end
        checks++; if (!ok || wr_q.size() - wr_base !== 3) begin errors++; $display("FAIL arb_nwr: got %0d required 3", wr_q.size() - wr_base); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (wr_q[wr_base + i] !== exp_q[i]) begin errors++; $display("FAIL arb_wr%0d: got %h required %h", i, wr_q[wr_base + i], exp_q[i]); end
            end
        end
        // A core request already in PASS finishes before the loader writes.
        lat = 3;
        begin_load();
        rd_base = rd_addr_q.size();
        core_addr = 25'h0BEEF0; core_req = 1'b1;
        repeat (2) @(negedge clk);
        wr_byte(8'd1, 25'h20, 8'h3C, 1'b1);
        wait_core(rd_base, okc);
        end_load();
        wait_idle(ok);
        checks++; if (!okc || rd_seen_q[rd_base] !== wr_base) begin errors++; $display("FAIL pass_first: core done %b, loader writes before core %0d required 0", okc, okc ? rd_seen_q[rd_base] - wr_base : -1); end
        checks++; if (!ok || wr_q.size() - wr_base !== 1 || wr_q[wr_base] !== {25'h010020, 8'h3C})
            begin errors++; $display("FAIL pass_then_wr: writes got %0d required 1 at 0x010020", wr_q.size() - wr_base); end
    endtask

    task automatic test_reset_mid();
        begin_load();
        stall = 1'b1;
        wr_byte(8'd1, 25'h1FFFFFF, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) wr_byte(8'd0, 25'h200 + 25'(i), 8'($urandom), 1'b0);
        end_load();
        checks++; if (sdram_req !== 1'b1 || range_err !== 1'b1) begin errors++; $display("FAIL rst_pre: req/range got %b/%b required 1/1", sdram_req, range_err); end
        reset = 1'b1;
        #1;
        checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", sdram_req); end
        @(negedge clk);
        checks++; if ({hold_reset, range_err, overrun, load_done, core_ready} !== 5'd0)
            begin errors++; $display("FAIL rst_flags: got %b required 00000", {hold_reset, range_err, overrun, load_done, core_ready}); end
        checks++; if (byte_count !== 25'd0) begin errors++; $display("FAIL rst_count: got %0d required 0", byte_count); end
        reset = 1'b0;
        stall = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (wr_q.size() - wr_base !== 0) begin errors++; $display("FAIL rst_fifo: writes after reset got %0d required 0", wr_q.size() - wr_base); end
        checks++; if (hold_reset !== 1'b0 || sdram_req !== 1'b0) begin errors++; $display("FAIL rst_idle: hold/req got %b/%b required 0/0", hold_reset, sdram_req); end
        checks++; if (done_cnt - done_base !== 0) begin errors++; $display("FAIL rst_done: got %0d required 0", done_cnt - done_base); end
    endtask

    initial begin
        test_reset();
        test_rom_load();
        test_cart();
        test_range();
        test_random();
        test_overrun();
        test_core_arb();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
